// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: branch encodings, reset/trap
// vector defaults, next-PC source enumeration and the branch-condition decode.
package pc_pkg;

   localparam int unsigned XLEN_DEF = 32;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

   // Branch field encodings from the control unit; unlisted codes mean no branch.
   localparam logic [2:0] BR_NONE = 3'b000;
   localparam logic [2:0] BR_EQ   = 3'b001;
   localparam logic [2:0] BR_NE   = 3'b010;
   localparam logic [2:0] BR_LT   = 3'b011;
   localparam logic [2:0] BR_GE   = 3'b100;

   // Which priority level produced the next PC.
   typedef enum logic [2:0] {
      SrcSeq,
      SrcBranch,
      SrcJal,
      SrcJalr,
      SrcTrap
   } pc_src_e;

   // Branch condition from the ALU flags: zero = equal, result = less-than.
   function automatic logic branch_cond(input logic [2:0] br,
                                        input logic       zero,
                                        input logic       result);
      logic cond;
      case (br)
         BR_EQ:   cond = zero;
         BR_NE:   cond = ~zero;
         BR_LT:   cond = result;
         BR_GE:   cond = ~result;
         default: cond = 1'b0;
      endcase
      return cond;
   endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational next-PC selection: target arithmetic, priority mux and
// misaligned-target detection. Holds no state.
module pc_target_sel
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN        = XLEN_DEF,
   parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEF),
   parameter int unsigned     ILEN_BYTES  = 4
) (
   input  logic [XLEN-1:0] pc,
   input  logic [2:0]      branch,
   input  logic            zero,
   input  logic            result,
   input  logic            jump,
   input  logic            jalr,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1Val,
   input  logic            trapReq,
   output logic [XLEN-1:0] nextPc,
   output logic [XLEN-1:0] linkPc,
   output logic            taken,
   output logic            misalignDet,
   output logic [XLEN-1:0] badTgt,
   output pc_src_e         src
);

   // ILEN_BYTES is a power of two, so alignment reduces to a low-bit mask.
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] jalr_tgt;
   logic [XLEN-1:0] sel_tgt;
   logic            br_hit;

   // Sums wrap silently mod 2^XLEN.
   assign linkPc   = pc + XLEN'(ILEN_BYTES);
   assign br_tgt   = pc + imm;
   assign jalr_sum = rs1Val + imm;
   assign jalr_tgt = jalr_sum & ~XLEN'(1);
   assign br_hit   = branch_cond(branch, zero, result);

   // Priority mux: trap, JALR, JAL, conditional branch, sequential.
   always_comb begin
      src     = SrcSeq;
      sel_tgt = linkPc;
      if (trapReq) begin
         src     = SrcTrap;
         sel_tgt = TRAP_VECTOR;
      end else if (jalr) begin
         src     = SrcJalr;
         sel_tgt = jalr_tgt;
      end else if (jump) begin
         src     = SrcJal;
         sel_tgt = br_tgt;
      end else if (br_hit) begin
         src     = SrcBranch;
         sel_tgt = br_tgt;
      end
   end

   // Control transfers to a misaligned target are redirected to the trap vector.
   always_comb begin
      taken       = (src == SrcJalr) || (src == SrcJal) || (src == SrcBranch);
      misalignDet = taken && ((sel_tgt & ALIGN_MASK) != '0);
      nextPc      = misalignDet ? TRAP_VECTOR : sel_tgt;
      badTgt      = sel_tgt;
   end

endmodule

// File: rtl/pc_gen.sv
// Program-counter unit: architectural PC, misaligned-target capture and
// retired-instruction counter. Next-PC logic lives in pc_target_sel.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
   parameter int unsigned     ILEN_BYTES   = 4,
   parameter int unsigned     CNT_W        = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic [2:0]       branch,
   input  logic             zero,
   input  logic             result,
   input  logic             jump,
   input  logic             jalr,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  rs1Val,
   input  logic             trapReq,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  nextPc,
   output logic [XLEN-1:0]  linkPc,
   output logic             taken,
   output logic             misalign,
   output logic [XLEN-1:0]  badAddr,
   output logic [CNT_W-1:0] instret
);

   logic [XLEN-1:0]  pc_q, pc_d;
   logic             misalign_q, misalign_d;
   logic [XLEN-1:0]  bad_addr_q, bad_addr_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic             misalign_det;
   logic [XLEN-1:0]  bad_tgt;
   pc_src_e          src;

   pc_target_sel #(
      .XLEN        (XLEN),
      .TRAP_VECTOR (TRAP_VECTOR),
      .ILEN_BYTES  (ILEN_BYTES)
   ) u_target_sel (
      .pc          (pc_q),
      .branch      (branch),
      .zero        (zero),
      .result      (result),
      .jump        (jump),
      .jalr        (jalr),
      .imm         (imm),
      .rs1Val      (rs1Val),
      .trapReq     (trapReq),
      .nextPc      (nextPc),
      .linkPc      (linkPc),
      .taken       (taken),
      .misalignDet (misalign_det),
      .badTgt      (bad_tgt),
      .src         (src)
   );

   // Next-state: a trap overrides stall but never retires; misalign is a one-cycle pulse.
   always_comb begin
      pc_d       = pc_q;
      instret_d  = instret_q;
      misalign_d = 1'b0;
      bad_addr_d = bad_addr_q;
      if (src == SrcTrap) begin
         pc_d = nextPc;
      end else if (!stall) begin
         pc_d       = nextPc;
         instret_d  = instret_q + CNT_W'(1);
         misalign_d = misalign_det;
         if (misalign_det) begin
            bad_addr_d = bad_tgt;
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         misalign_q <= 1'b0;
         bad_addr_q <= '0;
         instret_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
         bad_addr_q <= bad_addr_d;
         instret_q  <= instret_d;
      end
   end

   assign pc       = pc_q;
   assign misalign = misalign_q;
   assign badAddr  = bad_addr_q;
   assign instret  = instret_q;

endmodule
